// File: rtl/status_flag_sequencer_pkg.sv
// Shared definitions for the status flag sequencer: FSM state encodings,
// grant source IDs and default shadow stack sizing.
package status_flag_sequencer_pkg;

    localparam int STACK_DEPTH_DEF = 4;
    localparam int DEPTH_W_DEF     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        SAVE  = 2'd2,
        NOP   = 2'd3
    } seqState_t;

    typedef enum logic [1:0] {
        SRC_ALU     = 2'd0,
        SRC_BUS     = 2'd1,
        SRC_RESTORE = 2'd2,
        SRC_SAVE    = 2'd3
    } srcId_t;

endpackage

// File: rtl/status_flag_sequencer_shadow_stack.sv
// LIFO of saved C/Z pairs; entry 0 is always the top of stack, so pushes
// shift older entries down and pops shift them back up.
module status_shadow_stack
    import status_flag_sequencer_pkg::*;
#(
    parameter int STACK_DEPTH = STACK_DEPTH_DEF,
    parameter int DEPTH_W     = DEPTH_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [1:0]         din,
    output logic [1:0]         dout,
    output logic               full,
    output logic               empty,
    output logic [DEPTH_W-1:0] depth
);

    logic [1:0] mem [STACK_DEPTH];

    assign full  = (depth == DEPTH_W'(STACK_DEPTH));
    assign empty = (depth == '0);
    assign dout  = mem[0];

    // Contents are not reset; only the depth counter defines what is valid.
    always_ff @(posedge clock) begin
        if (push && !full) begin
            mem[0] <= din;
            for (int i = 1; i < STACK_DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end else if (pop && !empty) begin
            for (int i = 0; i < STACK_DEPTH - 1; i++) begin
                mem[i] <= mem[i+1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            depth <= '0;
        end else if (push && !full) begin
            depth <= depth + DEPTH_W'(1);
        end else if (pop && !empty) begin
            depth <= depth - DEPTH_W'(1);
        end
    end

endmodule

// File: rtl/status_flag_sequencer.sv
// Owns the active-low load strobe of the carry/zero status register and
// arbitrates ALU, bus and shadow-restore writes. STATUS_SHADOW_EN adds the shadow stack.
//
// state | meaning
// IDLE  | arbitrate save > restore > bus > alu, latch write data at grant
// WRITE | status register load strobe low, ack the granted writer
// SAVE  | save_ack, overflow reported if the push was refused
// NOP   | ack with no register write (empty restore, or save/restore without stack)
module status_flag_sequencer
    import status_flag_sequencer_pkg::*;
#(
    parameter int STACK_DEPTH = STACK_DEPTH_DEF,
    parameter int DEPTH_W     = DEPTH_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               alu_req,
    input  logic               alu_c,
    input  logic               alu_z,
    output logic               alu_ack,
    input  logic               bus_req,
    input  logic               bus_c,
    input  logic               bus_z,
    output logic               bus_ack,
    input  logic               save_req,
    output logic               save_ack,
    input  logic               restore_req,
    output logic               restore_ack,
    input  logic               status_c,
    input  logic               status_z,
    output logic               status_not_load,
    output logic               status_c_in,
    output logic               status_z_in,
    output logic               busy,
    output logic [DEPTH_W-1:0] stack_depth,
    output logic               err_overflow,
    output logic               err_underflow
);

    localparam bit unusedCfgOk = ((2 ** DEPTH_W) > STACK_DEPTH);

    seqState_t state, nextState;
    srcId_t    src, nextSrc;
    logic      cLatch, zLatch, nextC, nextZ;
    logic      ackEn;

`ifdef STATUS_SHADOW_EN
    logic               stackPush, stackPop, stackFull, stackEmpty;
    logic [1:0]         stackDout;
    logic [DEPTH_W-1:0] stackDepth;
    logic               ovfPending, nextOvf;

    status_shadow_stack #(
        .STACK_DEPTH (STACK_DEPTH),
        .DEPTH_W     (DEPTH_W)
    ) u_stack (
        .clock (clock),
        .reset (reset),
        .push  (stackPush),
        .pop   (stackPop),
        .din   ({status_c, status_z}),
        .dout  (stackDout),
        .full  (stackFull),
        .empty (stackEmpty),
        .depth (stackDepth)
    );
`else
    logic unusedStatus;
    assign unusedStatus = status_c ^ status_z;
`endif

    always_comb begin
        nextState = state;
        nextSrc   = src;
        nextC     = cLatch;
        nextZ     = zLatch;
`ifdef STATUS_SHADOW_EN
        stackPush = 1'b0;
        stackPop  = 1'b0;
        nextOvf   = ovfPending;
`endif
        case (state)
            IDLE: begin
                if (save_req) begin
                    nextSrc = SRC_SAVE;
`ifdef STATUS_SHADOW_EN
                    nextState = SAVE;
                    stackPush = ~stackFull;
                    nextOvf   = stackFull;
`else
                    nextState = NOP;
`endif
                end else if (restore_req) begin
                    nextSrc = SRC_RESTORE;
`ifdef STATUS_SHADOW_EN
                    if (stackEmpty) begin
                        nextState = NOP;
                    end else begin
                        stackPop  = 1'b1;
                        nextC     = stackDout[1];
                        nextZ     = stackDout[0];
                        nextState = WRITE;
                    end
`else
                    nextState = NOP;
`endif
                end else if (bus_req) begin
                    nextSrc   = SRC_BUS;
                    nextC     = bus_c;
                    nextZ     = bus_z;
                    nextState = WRITE;
                end else if (alu_req) begin
                    nextSrc   = SRC_ALU;
                    nextC     = alu_c;
                    nextZ     = alu_z;
                    nextState = WRITE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            src    <= SRC_ALU;
            cLatch <= 1'b0;
            zLatch <= 1'b0;
`ifdef STATUS_SHADOW_EN
            ovfPending <= 1'b0;
`endif
        end else begin
            state  <= nextState;
            src    <= nextSrc;
            cLatch <= nextC;
            zLatch <= nextZ;
`ifdef STATUS_SHADOW_EN
            ovfPending <= nextOvf;
`endif
        end
    end

    // Reset overrides a WRITE in flight: no load, and no completion reported.
    assign ackEn           = ~reset;
    assign status_not_load = ~(state == WRITE) | reset;
    assign status_c_in     = cLatch;
    assign status_z_in     = zLatch;
    assign busy            = (state != IDLE);

    assign alu_ack     = ackEn & (state == WRITE) & (src == SRC_ALU);
    assign bus_ack     = ackEn & (state == WRITE) & (src == SRC_BUS);
    assign save_ack    = ackEn & ((state == SAVE) | ((state == NOP) & (src == SRC_SAVE)));
    assign restore_ack = ackEn & ((state == WRITE) | (state == NOP)) & (src == SRC_RESTORE);

`ifdef STATUS_SHADOW_EN
    assign err_overflow  = ackEn & (state == SAVE) & ovfPending;
    assign err_underflow = ackEn & (state == NOP) & (src == SRC_RESTORE);
    assign stack_depth   = stackDepth;
`else
    assign err_overflow  = 1'b0;
    assign err_underflow = 1'b0;
    assign stack_depth   = '0;
`endif

endmodule
